// File: rtl/arbitro_ram.sv
// Shares the 16-word data RAM between processor Load/Store and an external loader port.
// Optional saturating conflict counter enabled by defining ARBITRO_RAM_CONFLITOS_EN.
module arbitro_ram #(
  parameter int LARGURA    = 8,
  parameter int MAX_ESPERA = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_read,
  input  logic               cpu_write,
  input  logic [3:0]         cpu_addr,
  input  logic [LARGURA-1:0] cpu_wdata,
  output logic [LARGURA-1:0] cpu_rdata,
  output logic               cpu_stall,
  input  logic               ext_req,
  input  logic               ext_we,
  input  logic [3:0]         ext_addr,
  input  logic [LARGURA-1:0] ext_wdata,
  output logic               ext_ack,
  output logic [LARGURA-1:0] ext_rdata,
  output logic [3:0]         ram_addr,
  output logic [LARGURA-1:0] ram_wdata,
  output logic               ram_we,
  output logic               ram_re,
  input  logic [LARGURA-1:0] ram_rdata,
  output logic [7:0]         conflitos,
  output logic [1:0]         estado_dbg
);

  localparam int EW = (MAX_ESPERA < 1) ? 1 : $clog2(MAX_ESPERA + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_RD   = 2'd1,
    EXT_DONE = 2'd2
  } estado_t;

  estado_t       state_q, state_d;
  logic [EW-1:0] espera_q, espera_d;
  logic          ext_we_q, ext_we_d;
  logic          cpu_req;
  logic          ext_wins;

  assign cpu_req  = cpu_read | cpu_write;
  assign ext_wins = ext_req && (!cpu_req || espera_q == EW'(MAX_ESPERA));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      espera_q <= '0;
      ext_we_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      espera_q <= espera_d;
      ext_we_q <= ext_we_d;
    end
  end

  // Everything is gated by rst so a request present during reset never reaches the RAM.
  always_comb begin
    state_d   = state_q;
    espera_d  = espera_q;
    ext_we_d  = ext_we_q;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    cpu_stall = 1'b0;
    ext_ack   = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          if (ext_wins) begin
            ram_addr  = ext_addr;
            ram_wdata = ext_wdata;
            ram_we    = ext_we;
            ram_re    = !ext_we;
            cpu_stall = cpu_req;
            ext_we_d  = ext_we;
            espera_d  = '0;
            state_d   = EXT_DONE;
          end else if (cpu_req) begin
            if (ext_req && espera_q != EW'(MAX_ESPERA)) espera_d = espera_q + EW'(1);
            ram_addr = cpu_addr;
            if (cpu_write) begin
              ram_wdata = cpu_wdata;
              ram_we    = 1'b1;
            end else begin
              ram_re    = 1'b1;
              cpu_stall = 1'b1;
              state_d   = CPU_RD;
            end
          end
        end
        CPU_RD: state_d = IDLE;
        EXT_DONE: begin
          ext_ack   = 1'b1;
          cpu_stall = cpu_req;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign cpu_rdata  = (!rst && state_q == CPU_RD) ? ram_rdata : '0;
  assign ext_rdata  = (!rst && state_q == EXT_DONE && !ext_we_q) ? ram_rdata : '0;
  assign estado_dbg = state_q;

`ifdef ARBITRO_RAM_CONFLITOS_EN
  logic [7:0] conflitos_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      conflitos_q <= '0;
    end else if (state_q == IDLE && cpu_req && ext_req && conflitos_q != 8'hFF) begin
      conflitos_q <= conflitos_q + 8'd1;
    end
  end

  assign conflitos = conflitos_q;
`else
  assign conflitos = '0;
`endif

endmodule

// File: tb/tb_arbitro_ram.sv
// Directed bench for arbitro_ram with a behavioural synchronous RAM and a read-data scoreboard.
module tb_arbitro_ram;

  localparam int LARGURA = 8;
  localparam logic [1:0] S_IDLE = 2'd0, S_CPU_RD = 2'd1, S_EXT_DONE = 2'd2;

  logic               clk = 1'b0;
  logic               rst;
  logic               cpu_read, cpu_write;
  logic [3:0]         cpu_addr;
  logic [LARGURA-1:0] cpu_wdata, cpu_rdata;
  logic               cpu_stall;
  logic               ext_req, ext_we;
  logic [3:0]         ext_addr;
  logic [LARGURA-1:0] ext_wdata, ext_rdata;
  logic               ext_ack;
  logic [3:0]         ram_addr;
  logic [LARGURA-1:0] ram_wdata, ram_rdata;
  logic               ram_we, ram_re;
  logic [7:0]         conflitos;
  logic [1:0]         estado_dbg;

  int checks = 0;
  int errors = 0;
  int exp_conf = 0;
  logic [LARGURA-1:0] exp_q[$];
  logic [LARGURA-1:0] exp_mem[16];
  logic [LARGURA-1:0] mem[16];
  logic [LARGURA-1:0] popped;

  arbitro_ram #(.LARGURA(LARGURA), .MAX_ESPERA(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_ack(ext_ack), .ext_rdata(ext_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_re(ram_re), .ram_rdata(ram_rdata),
    .conflitos(conflitos), .estado_dbg(estado_dbg)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Behavioural RAM macro: write and one-cycle synchronous read.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_addr];
  end

  // Driver tasks
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle_inputs();
    cpu_read = 0; cpu_write = 0; cpu_addr = '0; cpu_wdata = '0;
    ext_req = 0; ext_we = 0; ext_addr = '0; ext_wdata = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pop(input string tag, input logic [LARGURA-1:0] obs);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed %0h expected <empty scoreboard>", tag, obs);
    end else begin
      popped = exp_q.pop_front();
      chk(tag, 32'(obs), 32'(popped));
    end
  endtask

  task automatic chk_conf(input string tag);
`ifdef ARBITRO_RAM_CONFLITOS_EN
    chk(tag, 32'(conflitos), 32'(exp_conf));
`else
    chk(tag, 32'(conflitos), 32'd0);
`endif
  endtask

  initial begin
    // Reset with requests present: nothing may reach the RAM.
    idle_inputs();
    rst = 1; cpu_write = 1; ext_req = 1; ext_we = 1;
    next_cycle(); settle();
    chk("rst_state", 32'(estado_dbg), 32'(S_IDLE));
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_re", 32'(ram_re), 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_ack", 32'(ext_ack), 32'd0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_ext_rdata", 32'(ext_rdata), 32'd0);
    chk_conf("rst_conflitos");

    // Processor store then load.
    next_cycle();
    rst = 0; idle_inputs();
    cpu_write = 1; cpu_addr = 4'h3; cpu_wdata = 8'hA5; exp_mem[3] = 8'hA5;
    settle();
    chk("st_we", 32'(ram_we), 32'd1);
    chk("st_addr", 32'(ram_addr), 32'h3);
    chk("st_wdata", 32'(ram_wdata), 32'hA5);
    chk("st_stall", 32'(cpu_stall), 32'd0);
    next_cycle();
    cpu_write = 0; cpu_read = 1; cpu_addr = 4'h3; exp_q.push_back(exp_mem[3]);
    settle();
    chk("ld_re", 32'(ram_re), 32'd1);
    chk("ld_stall0", 32'(cpu_stall), 32'd1);
    next_cycle();
    cpu_read = 0;
    settle();
    chk("ld_state", 32'(estado_dbg), 32'(S_CPU_RD));
    chk("ld_stall1", 32'(cpu_stall), 32'd0);
    chk("ld_ram_re", 32'(ram_re), 32'd0);
    chk_pop("ld_rdata", cpu_rdata);

    // External write then read.
    next_cycle();
    ext_req = 1; ext_we = 1; ext_addr = 4'h7; ext_wdata = 8'h3C; exp_mem[7] = 8'h3C;
    settle();
    chk("ew_we", 32'(ram_we), 32'd1);
    chk("ew_addr", 32'(ram_addr), 32'h7);
    chk("ew_wdata", 32'(ram_wdata), 32'h3C);
    chk("ew_ack0", 32'(ext_ack), 32'd0);
    next_cycle(); settle();
    chk("ew_ack1", 32'(ext_ack), 32'd1);
    chk("ew_done_we", 32'(ram_we), 32'd0);
    next_cycle();
    ext_we = 0; ext_wdata = '0; exp_q.push_back(exp_mem[7]);
    settle();
    chk("er_re", 32'(ram_re), 32'd1);
    chk("er_we", 32'(ram_we), 32'd0);
    next_cycle(); settle();
    chk("er_ack", 32'(ext_ack), 32'd1);
    chk_pop("er_rdata", ext_rdata);

    // Read and write together: only the write happens.
    next_cycle();
    idle_inputs();
    cpu_read = 1; cpu_write = 1; cpu_addr = 4'h2; cpu_wdata = 8'h11; exp_mem[2] = 8'h11;
    settle();
    chk("rw_we", 32'(ram_we), 32'd1);
    chk("rw_re", 32'(ram_re), 32'd0);
    chk("rw_addr", 32'(ram_addr), 32'h2);
    chk("rw_wdata", 32'(ram_wdata), 32'h11);
    next_cycle();
    cpu_write = 0; cpu_addr = 4'h3;
    ext_req = 1; ext_we = 0; ext_addr = 4'h2;
    settle();
    chk("rw_state", 32'(estado_dbg), 32'(S_IDLE));

    // Continuous loads with ext_req held: external wins on its 5th IDLE cycle.
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(exp_mem[3]); exp_conf++;
      chk("starve_cpu_re", 32'(ram_re), 32'd1);
      chk("starve_cpu_addr", 32'(ram_addr), 32'h3);
      chk("starve_ack", 32'(ext_ack), 32'd0);
      next_cycle(); settle();
      chk("starve_rd_state", 32'(estado_dbg), 32'(S_CPU_RD));
      chk_pop("starve_rdata", cpu_rdata);
      next_cycle(); settle();
    end
    exp_q.push_back(exp_mem[2]); exp_conf++;
    chk("ovr_re", 32'(ram_re), 32'd1);
    chk("ovr_addr", 32'(ram_addr), 32'h2);
    chk("ovr_stall", 32'(cpu_stall), 32'd1);
    next_cycle(); settle();
    chk("ovr_done_state", 32'(estado_dbg), 32'(S_EXT_DONE));
    chk("ovr_done_stall", 32'(cpu_stall), 32'd1);
    chk("ovr_ack", 32'(ext_ack), 32'd1);
    chk_pop("ovr_rdata", ext_rdata);
    // Cleared wait counter: a fresh conflict goes to the processor again.
    next_cycle();
    exp_q.push_back(exp_mem[3]); exp_conf++;
    settle();
    chk("post_cpu_re", 32'(ram_re), 32'd1);
    chk("post_cpu_addr", 32'(ram_addr), 32'h3);
    chk("post_stall", 32'(cpu_stall), 32'd1);
    next_cycle();
    cpu_read = 0;
    settle();
    chk_pop("post_rdata", cpu_rdata);
    chk_conf("conflitos_count");

    // ext_req still held, processor quiet: grant, then reset in EXT_DONE.
    next_cycle();
    exp_q.push_back(exp_mem[2]);
    settle();
    chk("pre_rst_grant", 32'(ram_re), 32'd1);
    next_cycle();
    rst = 1;
    settle();
    chk("abort_ack", 32'(ext_ack), 32'd0);
    chk("abort_rdata", 32'(ext_rdata), 32'd0);
    chk("abort_ram_re", 32'(ram_re), 32'd0);
    void'(exp_q.pop_front());
    exp_conf = 0;
    next_cycle();
    rst = 0;
    exp_q.push_back(exp_mem[2]);
    settle();
    chk("regrant_state", 32'(estado_dbg), 32'(S_IDLE));
    chk("regrant_re", 32'(ram_re), 32'd1);
    chk("regrant_addr", 32'(ram_addr), 32'h2);
    chk_conf("conflitos_after_rst");
    next_cycle(); settle();
    chk("regrant_ack", 32'(ext_ack), 32'd1);
    chk_pop("regrant_rdata", ext_rdata);
    next_cycle();
    idle_inputs();
    settle();
    chk("final_state", 32'(estado_dbg), 32'(S_IDLE));
    chk("final_ack", 32'(ext_ack), 32'd0);
    chk("final_stall", 32'(cpu_stall), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arbitro_ram.md
# arbitro_ram

Arbiter and access sequencer for the 16-word data RAM. It shares the RAM between the processor datapath, which issues Load/Store through Read_RAM/Write_RAM/endereco_dados, and an external loader/debug port. It produces a stall that holds the PC and register write while a processor access waits or while read data is pending. It sits between the decoder/datapath and the RAM macro.

## Interface
- LARGURA, 8, data word width
- MAX_ESPERA, 4, cycles an external request may be refused before it overrides the processor (0 = external always wins)

- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- cpu_read  in  1  processor load request (Read_RAM)
- cpu_write  in  1  processor store request (Write_RAM)
- cpu_addr  in  4  processor word address (endereco_dados)
- cpu_wdata  in  LARGURA  store data
- cpu_rdata  out  LARGURA  load data, valid in CPU_RD
- cpu_stall  out  1  hold PC, register write and processor request
- ext_req  in  1  external request, held until ext_ack
- ext_we  in  1  1 = write, 0 = read; stable while ext_req
- ext_addr  in  4  external word address
- ext_wdata  in  LARGURA  external write data
- ext_ack  out  1  one-cycle completion pulse
- ext_rdata  out  LARGURA  read data, valid while ext_ack
- ram_addr  out  4  RAM address
- ram_wdata  out  LARGURA  RAM write data
- ram_we  out  1  RAM write enable
- ram_re  out  1  RAM read enable
- ram_rdata  in  LARGURA  synchronous RAM read data, one cycle after ram_re
- conflitos  out  8  saturating conflict counter (see Configuration)

## Operation
- FSM states:
  - IDLE: the only state that grants access.
  - CPU_RD: processor read data cycle.
  - EXT_DONE: external completion cycle.
- Processor request: cpu_read or cpu_write. If both are set, the access is a write and the read is ignored.
- Winner in IDLE:
  - Only one side requests: that side wins.
  - Both sides request: the processor wins, unless espera == MAX_ESPERA, in which case external wins.
- Granted processor write:
  - ram_we=1, ram_addr=cpu_addr, ram_wdata=cpu_wdata.
  - cpu_stall=0; FSM stays in IDLE.
- Granted processor read:
  - ram_re=1, cpu_stall=1, next state CPU_RD.
- CPU_RD:
  - cpu_rdata=ram_rdata, cpu_stall=0, no RAM operation.
  - Next state IDLE.
- Granted external access:
  - ram_* driven from ext_*; ram_we=ext_we, ram_re=!ext_we.
  - Next state EXT_DONE; espera cleared.
- EXT_DONE:
  - ext_ack=1; ext_rdata=ram_rdata for a read, don't-care for a write.
  - No RAM operation; ext_req is ignored.
  - Next state IDLE.
- cpu_stall=1 whenever a processor request is present and not granted: external won in IDLE, or the FSM is in EXT_DONE.
- espera counter:
  - Increments in IDLE when ext_req=1 and the processor wins.
  - Saturates at MAX_ESPERA.
  - Clears when external is granted.
  - Width: clog2(MAX_ESPERA+1), minimum 1.
- ram_* outputs are combinational from state and the granted request. ram_addr and ram_wdata read 0 when no access is granted.

## Timing
- Reset values:
  - State IDLE, espera 0, conflitos 0.
  - ext_ack 0, ext_rdata 0, cpu_rdata 0.
  - ram_we 0, ram_re 0, cpu_stall 0.
- While rst=1: no RAM operation, cpu_stall=0, ext_ack=0.
- Reset during CPU_RD or EXT_DONE aborts the access. No ack is issued; the external requester keeps ext_req asserted and is re-served.
- Latencies:
  - Processor write: 1 cycle, no stall.
  - Processor read: 2 cycles, stall in the first.
  - External access: grant cycle plus ack cycle, ack 1 cycle after grant.
- After EXT_DONE the FSM always returns to IDLE. A still-held ext_req in the following IDLE cycle is a new request.
- A processor request held continuously is served no later than 2 cycles after it would otherwise win (one external grant plus EXT_DONE).

## Configuration
- ARBITRO_RAM_CONFLITOS_EN:
  - Defined: conflitos increments by 1 on every IDLE cycle in which both sides request, saturating at 255, and clears on reset.
  - Undefined: conflitos is tied to 0 and no counter logic exists.

## Test plan
- Processor store, then load: write addr 0x3 data 0xA5, no stall. Then read addr 0x3: stall=1 in cycle 0; cpu_rdata=0xA5 with stall=0 in cycle 1.
- External write then read: ext write 0x7 data 0x3C gives ext_ack 1 cycle after grant. Ext read 0x7 returns ext_ack with ext_rdata=0x3C.
- Continuous processor loads with ext_req held, MAX_ESPERA=4: the external is granted on its 5th IDLE cycle. cpu_stall=1 during that grant and during EXT_DONE; espera returns to 0.
- Simultaneous request with espera < MAX_ESPERA: processor wins, espera increments. With ARBITRO_RAM_CONFLITOS_EN defined, conflitos increments by 1 per such cycle.
- cpu_read and cpu_write both 1, addr 0x2, data 0x11: a single write occurs, ram_re=0, FSM stays in IDLE.
- rst asserted in EXT_DONE: ext_ack stays 0 and all outputs return to reset values. After release with ext_req held, the access is re-granted and acked.
